// File: rtl/rv32v_decode_execute_stage.sv
// Registered decode->execute vector stage: main + skid register, valid/ready, flush, per-lane masking.
// Optional saturating back-pressure counter on port stall_cycles when RV32V_DE_STALL_CNT_EN is defined.

module rv32v_de_lane #(
  parameter int LANE_W = 128
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [LANE_W-1:0] din,
  input  logic              en,
  input  logic              ld_m_in,
  input  logic              ld_m_skid,
  input  logic              ld_s,
  output logic [LANE_W-1:0] m_data,
  output logic              m_en
);
  logic [LANE_W-1:0] din_m, s_data;
  logic              s_en;

  // disabled lanes are zeroed at capture so execute never sees stale operands
  assign din_m = en ? din : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_data <= '0;
      m_en   <= 1'b0;
      s_data <= '0;
      s_en   <= 1'b0;
    end else begin
      if (ld_s) begin
        s_data <= din_m;
        s_en   <= en;
      end
      if (ld_m_skid) begin
        m_data <= s_data;
        m_en   <= s_en;
      end else if (ld_m_in) begin
        m_data <= din_m;
        m_en   <= en;
      end
    end
  end
endmodule

module rv32v_decode_execute_stage #(
  parameter int NUM_LANES = 2,
  parameter int LANE_W    = 128,
  parameter int CTRL_W    = 96
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        flush,
  input  logic                        dec_valid,
  output logic                        dec_ready,
  input  logic [CTRL_W-1:0]           dec_ctrl,
  input  logic [NUM_LANES*LANE_W-1:0] dec_lane_data,
  input  logic [NUM_LANES-1:0]        dec_lane_en,
  output logic                        ex_valid,
  input  logic                        ex_ready,
  output logic [CTRL_W-1:0]           ex_ctrl,
  output logic [NUM_LANES*LANE_W-1:0] ex_lane_data,
  output logic [NUM_LANES-1:0]        ex_lane_en,
  output logic [1:0]                  occupancy
`ifdef RV32V_DE_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_cycles
`endif
);
  logic                          m_valid, s_valid;
  logic [CTRL_W-1:0]             s_ctrl;
  logic                          accept, m_free;
  logic                          ld_m_in, ld_m_skid, ld_s;
  logic [NUM_LANES-1:0][LANE_W-1:0] din_lanes, ex_lanes;

  // ready depends only on skid state and flush, never on ex_ready
  assign dec_ready = !s_valid && !flush;
  assign accept    = dec_valid && dec_ready;
  assign m_free    = !m_valid || ex_ready;

  assign ld_m_skid = !flush && m_free && s_valid;
  assign ld_m_in   = !flush && m_free && !s_valid && accept;
  assign ld_s      = !flush && !m_free && accept;

  assign ex_valid  = m_valid;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_free) begin
      m_valid <= s_valid || accept;
      s_valid <= 1'b0;
    end else begin
      s_valid <= s_valid || accept;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_ctrl <= '0;
      s_ctrl  <= '0;
    end else begin
      if (ld_s)           s_ctrl  <= dec_ctrl;
      if (ld_m_skid)      ex_ctrl <= s_ctrl;
      else if (ld_m_in)   ex_ctrl <= dec_ctrl;
    end
  end

  assign din_lanes    = dec_lane_data;
  assign ex_lane_data = ex_lanes;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rv32v_de_lane #(.LANE_W(LANE_W)) u_lane (
      .CLK       (CLK),
      .nRST      (nRST),
      .din       (din_lanes[i]),
      .en        (dec_lane_en[i]),
      .ld_m_in   (ld_m_in),
      .ld_m_skid (ld_m_skid),
      .ld_s      (ld_s),
      .m_data    (ex_lanes[i]),
      .m_en      (ex_lane_en[i])
    );
  end

`ifdef RV32V_DE_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stall_cnt <= '0;
    else if (m_valid && !ex_ready && !flush && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall_cycles = stall_cnt;
`endif
endmodule

// File: tb/tb_rv32v_decode_execute_stage.sv
// Bench for rv32v_decode_execute_stage: queue model checked every cycle plus directed literal checks.
module tb_rv32v_decode_execute_stage;
  localparam int NL = 4;
  localparam int LW = 16;
  localparam int CW = 32;

  logic CLK = 0, nRST = 0, flush = 0, dec_valid = 0, ex_ready = 0;
  logic [CW-1:0]    dec_ctrl = '0;
  logic [NL*LW-1:0] dec_lane_data = '0;
  logic [NL-1:0]    dec_lane_en = '0;
  logic             dec_ready, ex_valid;
  logic [CW-1:0]    ex_ctrl;
  logic [NL*LW-1:0] ex_lane_data;
  logic [NL-1:0]    ex_lane_en;
  logic [1:0]       occupancy;
`ifdef RV32V_DE_STALL_CNT_EN
  logic [31:0]      stall_cycles;
`endif

  rv32v_decode_execute_stage #(.NUM_LANES(NL), .LANE_W(LW), .CTRL_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_ctrl(dec_ctrl),
    .dec_lane_data(dec_lane_data), .dec_lane_en(dec_lane_en),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ctrl(ex_ctrl),
    .ex_lane_data(ex_lane_data), .ex_lane_en(ex_lane_en),
    .occupancy(occupancy)
`ifdef RV32V_DE_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: the stage is a 2-deep FIFO whose head drives ex_*.
  typedef struct {
    logic [CW-1:0]    ctrl;
    logic [NL*LW-1:0] data;
    logic [NL-1:0]    en;
  } ent_t;
  ent_t q[$];

  function automatic logic [NL*LW-1:0] mask_lanes(input logic [NL*LW-1:0] d, input logic [NL-1:0] en);
    logic [NL*LW-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++)
      if (en[i]) r[i*LW +: LW] = d[i*LW +: LW];
    return r;
  endfunction

  always @(posedge CLK or negedge nRST) begin : model
    ent_t e;
    bit acc;
    if (!nRST) q.delete();
    else if (flush) q.delete();
    else begin
      acc = dec_valid && (q.size() < 2);
      if (q.size() > 0 && ex_ready) void'(q.pop_front());
      if (acc) begin
        e.ctrl = dec_ctrl;
        e.data = mask_lanes(dec_lane_data, dec_lane_en);
        e.en   = dec_lane_en;
        q.push_back(e);
      end
    end
  end

  always @(negedge CLK) begin : compare
    if (nRST) begin
      chk("m_ex_valid", ex_valid, q.size() > 0);
      chk("m_occupancy", occupancy, q.size());
      chk("m_dec_ready", dec_ready, (q.size() < 2) && !flush);
      if (q.size() > 0) begin
        chk("m_ex_ctrl", ex_ctrl, q[0].ctrl);
        chk("m_ex_lane_data", ex_lane_data, q[0].data);
        chk("m_ex_lane_en", ex_lane_en, q[0].en);
      end
    end
  end

  task automatic offer(input logic [CW-1:0] c, input logic [NL-1:0] en, input logic [LW-1:0] pat);
    dec_valid     = 1'b1;
    dec_ctrl      = c;
    dec_lane_en   = en;
    dec_lane_data = {NL{pat}};
  endtask

  initial begin
    // reset
    @(posedge CLK); #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    @(posedge CLK); #1 nRST = 1;
    @(negedge CLK);
    chk("idle_ex_valid", ex_valid, 0);
    chk("idle_dec_ready", dec_ready, 1);
    chk("idle_occupancy", occupancy, 0);
    chk("idle_ex_ctrl", ex_ctrl, 0);
    chk("idle_ex_lane_data", ex_lane_data, 0);
    chk("idle_ex_lane_en", ex_lane_en, 0);

    // streaming 1..8, no bubbles
    @(posedge CLK); #1;
    ex_ready = 1;
    offer(1, 4'b1111, 16'd1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK); #1;
      if (k < 8) offer(CW'(k + 1), (k % 2 == 1) ? 4'b1111 : 4'b0011, 16'(k + 1));
      else dec_valid = 0;
      @(negedge CLK);
      chk("stream_ex_valid", ex_valid, 1);
      chk("stream_ex_ctrl", ex_ctrl, k);
    end
    @(posedge CLK); #1;

    // back-pressure: A, B held, C waits
    ex_ready = 0;
    offer(32'hA, 4'b1111, 16'h00AA);
    @(posedge CLK); #1 offer(32'hB, 4'b1110, 16'h00BB);
    @(posedge CLK); #1 offer(32'hC, 4'b0111, 16'h00CC);
    @(negedge CLK);
    chk("bp_occupancy", occupancy, 2);
    chk("bp_dec_ready", dec_ready, 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bp_hold_occ", occupancy, 2);
    chk("bp_hold_ctrl", ex_ctrl, 32'hA);
    @(posedge CLK); #1 ex_ready = 1;
    @(negedge CLK);
    chk("bp_out_A", ex_ctrl, 32'hA);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bp_out_B", ex_ctrl, 32'hB);
    chk("bp_ready_back", dec_ready, 1);
    @(posedge CLK); #1 dec_valid = 0;
    @(negedge CLK);
    chk("bp_out_C", ex_ctrl, 32'hC);
    chk("bp_out_C_lanes", ex_lane_data, 64'h0000_00CC_00CC_00CC);
    @(posedge CLK); #1;

    // lane mask 0101
    offer(32'h55, 4'b0101, 16'hFFFF);
    @(posedge CLK); #1 dec_valid = 0;
    @(negedge CLK);
    chk("mask_lane_data", ex_lane_data, 64'h0000_FFFF_0000_FFFF);
    chk("mask_lane_en", ex_lane_en, 4'b0101);
    @(posedge CLK); #1;

    // flush while full
    ex_ready = 0;
    offer(32'h1A, 4'b1111, 16'h1111);
    @(posedge CLK); #1 offer(32'h1B, 4'b1111, 16'h2222);
    @(posedge CLK); #1;
    flush = 1;
    offer(32'h99, 4'b1111, 16'h9999);
    @(negedge CLK);
    chk("flush_dec_ready", dec_ready, 0);
    chk("flush_occ_before", occupancy, 2);
    @(posedge CLK); #1;
    flush = 0;
    offer(32'h77, 4'b1001, 16'h7777);
    @(negedge CLK);
    chk("flush_ex_valid", ex_valid, 0);
    chk("flush_occupancy", occupancy, 0);
    @(posedge CLK); #1 dec_valid = 0;
    @(negedge CLK);
    chk("post_flush_valid", ex_valid, 1);
    chk("post_flush_ctrl", ex_ctrl, 32'h77);
    chk("post_flush_lanes", ex_lane_data, 64'h7777_0000_0000_7777);

    // async reset mid-operation
    @(posedge CLK); #1 nRST = 0;
    #1;
    chk("mid_rst_valid", ex_valid, 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_ctrl", ex_ctrl, 0);
    @(posedge CLK); #1 nRST = 1;

`ifdef RV32V_DE_STALL_CNT_EN
    chk("stall_rst", stall_cycles, 0);
    ex_ready = 0;
    offer(32'h11, 4'b1111, 16'h0011);
    @(posedge CLK); #1 dec_valid = 0;
    repeat (5) @(posedge CLK);
    #1 flush = 1;
    @(posedge CLK); #1 flush = 0;
    @(negedge CLK);
    chk("stall_five", stall_cycles, 5);
    @(posedge CLK); #1;
    offer(32'h22, 4'b1111, 16'h0022);
    @(posedge CLK); #1 dec_valid = 0;
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt;
    repeat (3) @(posedge CLK);
    #1 chk("stall_saturate", stall_cycles, 32'hFFFF_FFFF);
    ex_ready = 1;
    @(posedge CLK); #1;
`endif

    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32v_decode_execute_stage.md
# rv32v_decode_execute_stage

Parametrised, lane-scalable pipeline register between the vector decode and vector execute stages. It replaces the fixed two-lane, purely combinational decode/execute signal bundle with a registered stage. The stage has a valid/ready handshake, a two-entry skid buffer for full throughput under back-pressure, and synchronous flush. Per-lane operand and control payloads are carried for NUM_LANES lanes with per-lane enables, alongside a shared control word (fu type, aluop, vl, stride, rd_sel, etc.) packed by decode.

## Interface
Parameters:
- NUM_LANES, default 2: number of vector lanes carried; legal values are 1 to 8.
- LANE_W, default 128: bits per lane payload (vs1/vs2/vs3/storedata/woffset/wen/mask, packed by decode).
- CTRL_W, default 96: bits of the shared control payload.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all held instructions.
- dec_valid  in  1  decode offers an instruction.
- dec_ready  out  1  stage accepts the offer; equals !skid_valid && !flush.
- dec_ctrl  in  CTRL_W  shared control payload.
- dec_lane_data  in  NUM_LANES*LANE_W  lane payloads; lane i occupies [i*LANE_W +: LANE_W].
- dec_lane_en  in  NUM_LANES  per-lane active flags.
- ex_valid  out  1  the main register holds an instruction.
- ex_ready  in  1  execute consumes the instruction.
- ex_ctrl  out  CTRL_W  registered control payload.
- ex_lane_data  out  NUM_LANES*LANE_W  registered lane payloads; disabled lanes are zero.
- ex_lane_en  out  NUM_LANES  registered lane enables.
- occupancy  out  2  number of held instructions (0, 1 or 2).
- stall_cycles  out  32  saturating back-pressure counter; present only with RV32V_DE_STALL_CNT_EN.

## Operation
- Storage is a main register (M, drives ex_*) and a skid register (S). Each has its own valid bit.
- Accept = dec_valid && dec_ready. Consume = ex_valid && ex_ready.
- On each edge without flush, the stage applies the first matching rule:
  - If M is empty or consumed, M loads from S if S is valid, otherwise from the input when Accept is true. S loads the input if S was valid and Accept is true; otherwise S is cleared.
  - If M is held (not consumed), an accepted input goes to S.
- Accept while S is valid cannot occur, because dec_ready is 0 in that case.
- Order is strict FIFO. No instruction is duplicated or dropped except by flush.
- Lane masking applies at capture: lane i data is stored as zero when dec_lane_en[i]=0. ex_lane_en mirrors the captured enables.
- flush takes priority over everything:
  - Both valid bits clear at the next edge.
  - dec_ready is 0 during the flush cycle, so no input is accepted.
  - A Consume in the flush cycle is still a legal handshake. Execute decides whether to honour it.
- Payload registers are updated only on load. Their contents are don't-care while invalid, except that reset zeroes them.
- occupancy = M.valid + S.valid.

## Timing
- Reset (nRST=0, async): both valid bits and all payloads are 0, and stall_cycles is 0. Resulting outputs: ex_valid=0, ex_ctrl=0, ex_lane_data=0, ex_lane_en=0, occupancy=0, dec_ready=1 (when flush=0).
- Latency: an instruction accepted at edge n shows ex_valid=1 with its payload after edge n.
- Throughput: 1 instruction/cycle while ex_ready=1.
- dec_ready is registered state plus flush, with no combinational path from ex_ready. ex_* are purely registered.
- Full: S valid means dec_ready=0. ready reasserts the cycle after a Consume drains S into M.
- Simultaneous Accept and Consume with S empty: M is replaced by the new instruction and occupancy stays at 1.
- Reset mid-operation discards all contents immediately, with no handshake.

## Configuration
- RV32V_DE_STALL_CNT_EN defined:
  - stall_cycles increments by 1 on each edge where ex_valid && !ex_ready && !flush.
  - It saturates at 0xFFFF_FFFF and is cleared only by nRST.
- Undefined: the stall_cycles port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset then idle: after nRST deasserts, check ex_valid=0, dec_ready=1, occupancy=0 and all ex_* zero.
- Streaming: send 8 back-to-back instructions with ex_ready=1, using dec_ctrl=1..8. ex_ctrl must read 1..8 on consecutive cycles, one cycle after each accept, with no bubbles.
- Back-pressure: hold ex_ready=0 and offer ctrl=A then B. occupancy must reach 2 and dec_ready fall to 0, and C is held off. Release ex_ready: the stage must output A, then B, then C in order, with nothing lost.
- Lane mask (NUM_LANES=4): send dec_lane_en=4'b0101 with all lane data 0xFF…. ex_lane_data lanes 1 and 3 must be 0, lanes 0 and 2 must be 0xFF…, and ex_lane_en must be 4'b0101.
- Flush while full: with occupancy=2, pulse flush with dec_valid=1. dec_ready=0 that cycle, and the next cycle shows ex_valid=0 and occupancy=0. The first post-flush accept appears with latency 1.
- Stall counter (macro on): hold ex_valid=1 with ex_ready=0 for 5 cycles, then 1 flush cycle. stall_cycles must equal 5. Preloading the counter to 0xFFFF_FFFE and stalling 3 cycles must leave it at 0xFFFF_FFFF.
